// File: rtl/data_mem_mmio.sv
// Data-side memory responder: word RAM plus an MMIO window holding a
// console TX FIFO, a free-running cycle counter and a compare interrupt.
module data_mem_mmio #(
    parameter int          RamAddrBits = 10,
    parameter int          FifoDepth   = 8,
    parameter logic [31:0] MmioBase    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  byte_slct,
    output logic [31:0] data_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int PtrBits = $clog2(FifoDepth);
    localparam logic [PtrBits:0] FullCount = (PtrBits + 1)'(FifoDepth);

    logic [31:0] ram [2**RamAddrBits];
    logic [7:0]  fifo_mem [FifoDepth];

    logic [PtrBits-1:0] wr_ptr;
    logic [PtrBits-1:0] rd_ptr;
    logic [PtrBits:0]   count;
    logic               ovf;
    logic               irq;
    logic [31:0]        cycle;
    logic [31:0]        compare;

    logic                   is_mmio;
    logic [1:0]             reg_off;
    logic [RamAddrBits-1:0] ram_idx;
    logic                   empty;
    logic                   full;
    logic                   wr_tx;
    logic                   clr_ovf;
    logic                   wr_cycle;
    logic                   wr_cmp;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic [31:0]            rd_reg;
    logic                   unused_addr;

    assign is_mmio  = addr_i[31:4] == MmioBase[31:4];
    assign reg_off  = addr_i[3:2];
    assign ram_idx  = addr_i[RamAddrBits+1:2];
    assign unused_addr = ^addr_i[1:0];

    assign empty    = count == '0;
    assign full     = count == FullCount;
    assign wr_tx    = we && is_mmio && reg_off == 2'd0 && byte_slct[0];
    assign clr_ovf  = we && is_mmio && reg_off == 2'd1 && byte_slct[0]
                      && data_i[2];
    assign wr_cycle = we && is_mmio && reg_off == 2'd2 && byte_slct == 4'hF;
    assign wr_cmp   = we && is_mmio && reg_off == 2'd3 && byte_slct == 4'hF;

    // A pop frees a slot in the same edge, so a push to a full FIFO still fits.
    assign pop      = !empty && tx_ready;
    assign push_ok  = wr_tx && (!full || pop);
    assign drop     = wr_tx && full && !pop;

    assign tx_valid  = !empty;
    assign tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign timer_irq = irq;

    always_ff @(posedge clk) begin
        if (we && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_slct[i]) begin
                    ram[ram_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            irq     <= 1'b0;
            cycle   <= '0;
            compare <= 32'hFFFF_FFFF;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_ovf) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
            cycle <= wr_cycle ? data_i : cycle + 32'd1;
            if (wr_cmp) begin
                compare <= data_i;
            end
            // A COMPARE write beats a match seen on the same edge.
            if (wr_cmp) begin
                irq <= 1'b0;
            end else if (cycle == compare) begin
                irq <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_reg = '0;
        case (reg_off)
            2'd1:    rd_reg = {28'b0, irq, ovf, full, empty};
            2'd2:    rd_reg = cycle;
            2'd3:    rd_reg = compare;
            default: rd_reg = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        if (rst && re) begin
            data_o = is_mmio ? rd_reg : ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: a queue/array reference model feeds
// expected reads and TX bytes to a negedge monitor.
module tb_data_mem_mmio;

    localparam logic [31:0] MB = 32'h1000_0000;
    localparam logic [31:0] TXA = MB;
    localparam logic [31:0] STA = MB + 32'd4;
    localparam logic [31:0] CYA = MB + 32'd8;
    localparam logic [31:0] CMA = MB + 32'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  byte_slct;
    logic [31:0] data_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    always #5 clk = ~clk;

    data_mem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .re        (re),
        .we        (we),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .byte_slct (byte_slct),
        .data_o    (data_o),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    int checks = 0;
    int passes = 0;
    bit run = 1'b0;

    logic [31:0] mram [int];
    logic [7:0]  mfifo [$];
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_rd [$];
    logic [31:0] mcyc;
    logic [31:0] mcmp;
    bit          mirq;
    bit          movf;
    logic [7:0]  last_tx;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic bit is_mm(logic [31:0] a);
        return a[31:4] == MB[31:4];
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r;
        int idx;
        r = '0;
        if (is_mm(a)) begin
            case (a[3:2])
                2'd1: r = {28'b0, mirq, movf, mfifo.size() == 8,
                           mfifo.size() == 0};
                2'd2: r = mcyc;
                2'd3: r = mcmp;
                default: r = '0;
            endcase
        end else begin
            idx = int'((a >> 2) % 1024);
            r = mram.exists(idx) ? mram[idx] : 32'hxxxx_xxxx;
        end
        return r;
    endfunction

    function automatic void model_update(bit w, logic [31:0] a,
                                         logic [31:0] d, logic [3:0] bs,
                                         bit rdy);
        int n;
        bit mm;
        bit pop;
        bit push;
        int idx;
        logic [31:0] word;
        logic [31:0] ncyc;
        n = mfifo.size();
        mm = is_mm(a);
        pop = n > 0 && rdy;
        push = w && mm && a[3:2] == 2'd0 && bs[0];
        ncyc = (w && mm && a[3:2] == 2'd2 && bs == 4'hF) ? d : mcyc + 1;
        if (w && mm && a[3:2] == 2'd3 && bs == 4'hF) begin
            mcmp = d;
            mirq = 1'b0;
        end else if (mcyc == mcmp) begin
            mirq = 1'b1;
        end
        if (w && mm && a[3:2] == 2'd1 && bs[0] && d[2]) movf = 1'b0;
        if (push && n == 8 && !pop) movf = 1'b1;
        if (w && !mm) begin
            idx = int'((a >> 2) % 1024);
            word = mram.exists(idx) ? mram[idx] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (bs[i]) word[8*i +: 8] = d[8*i +: 8];
            mram[idx] = word;
        end
        if (pop) void'(mfifo.pop_front());
        if (push && (n < 8 || pop)) begin
            mfifo.push_back(d[7:0]);
            exp_tx.push_back(d[7:0]);
        end
        mcyc = ncyc;
    endfunction

    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] bs,
                        input bit rdy, input bit use_lit = 1'b0,
                        input logic [31:0] lit = 32'h0);
        re = r;
        we = w;
        addr_i = a;
        data_i = d;
        byte_slct = bs;
        tx_ready = rdy;
        if (r) exp_rd.push_back(use_lit ? lit : model_read(a));
        @(posedge clk);
        model_update(w, a, d, bs, rdy);
        #1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (re) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    $display("FAIL rd_queue: read seen, none expected");
                end else begin
                    check("data_o", data_o, exp_rd.pop_front());
                end
            end
            check("tx_valid", tx_valid, mfifo.size() != 0);
            check("timer_irq", timer_irq, mirq);
            if (tx_valid && tx_ready) begin
                last_tx = tx_data;
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_queue: pop seen, none expected");
                end else begin
                    check("tx_data", tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rnd_ram_addr();
        return 32'h100 + 32'($urandom_range(0, 15)) * 4
               + (32'($urandom_range(0, 3)) << 12)
               + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1;
        re = 1'b1;
        we = 1'b0;
        addr_i = STA;
        data_i = '0;
        byte_slct = '0;
        tx_ready = 1'b0;
        mcyc = '0;
        mcmp = 32'hFFFF_FFFF;
        mirq = 1'b0;
        movf = 1'b0;
        last_tx = '0;
        #2 rst = 1'b0;
        #10;
        check("rst_data_o", data_o, 32'h0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h0);
        check("rst_irq", timer_irq, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b1;
        step(1, 0, CYA, 0, 0, 0, 1, 32'h0);
        step(1, 0, CMA, 0, 0, 0, 1, 32'hFFFF_FFFF);
        step(1, 0, STA, 0, 0, 0, 1, 32'h1);

        // RAM byte lanes and aliasing
        step(0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
        step(0, 1, 32'h40, 32'h0000_00AA, 4'h1, 0);
        step(1, 0, 32'h40, 0, 0, 0, 1, 32'hDEAD_BEAA);
        step(1, 0, 32'h1040, 0, 0, 0, 1, 32'hDEAD_BEAA);

        // Console FIFO overflow then drain
        for (int i = 0; i < 9; i++) step(0, 1, TXA, 32'h41 + i, 4'h1, 0);
        step(1, 0, STA, 0, 0, 0, 1, 32'h6);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
        check("drain_last", last_tx, 8'h48);
        step(1, 0, STA, 0, 0, 1, 1, 32'h5);

        // Full FIFO with simultaneous push and pop
        step(0, 1, STA, 32'h4, 4'hF, 0);
        for (int i = 0; i < 8; i++) step(0, 1, TXA, 32'h10 + i, 4'hF, 0);
        step(0, 1, TXA, 32'h5A, 4'h1, 1);
        step(1, 0, STA, 0, 0, 0, 1, 32'h2);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1);
        check("pushpop_last", last_tx, 8'h5A);

        // Timer compare
        step(0, 1, CYA, 32'd100, 4'hF, 0);
        step(0, 1, CMA, 32'd105, 4'hF, 0);
        for (int i = 0; i < 5; i++) step(1, 0, CYA, 0, 0, 0, 1, 32'd101 + i);
        check("irq_set", timer_irq, 1'b1);
        step(1, 0, STA, 0, 0, 0, 1, 32'h9);
        step(0, 1, CMA, 32'hFFFF_FFFF, 4'hF, 0);
        check("irq_clr", timer_irq, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 16; i++)
            step(0, 1, 32'h100 + i * 4, $urandom, 4'hF, 0);
        for (int i = 0; i < 400; i++) begin
            bit rdy;
            rdy = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: step(0, 1, rnd_ram_addr(), $urandom,
                        4'($urandom_range(0, 15)), rdy);
                1: step(1, 0, rnd_ram_addr(), 0, 0, rdy);
                2: step(1, 1, rnd_ram_addr(), $urandom,
                        4'($urandom_range(0, 15)), rdy);
                3: step(0, 1, TXA, $urandom, 4'($urandom_range(0, 15)), rdy);
                4: step(1, 0, MB + 32'($urandom_range(0, 3)) * 4, 0, 0, rdy);
                5: step(0, 1, STA, $urandom, 4'($urandom_range(0, 15)), rdy);
                6: step(0, 1, $urandom_range(0, 1) ? CYA : CMA, $urandom,
                        4'($urandom_range(0, 15)), rdy);
                default: step(0, 0, 0, 0, 0, rdy);
            endcase
        end

        // Async reset with bytes queued and irq pending
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 1, STA, 32'h4, 4'hF, 0);
        step(0, 1, CYA, 32'd200, 4'hF, 0);
        step(0, 1, CMA, 32'd202, 4'hF, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, TXA, 32'h61 + i, 4'h1, 0);
        check("pre_rst_irq", timer_irq, 1'b1);
        check("pre_rst_valid", tx_valid, 1'b1);
        rst = 1'b0;
        tx_ready = 1'b0;
        re = 1'b1;
        we = 1'b0;
        addr_i = 32'h40;
        exp_rd.push_back(32'h0);
        mfifo.delete();
        exp_tx.delete();
        mcyc = '0;
        mcmp = 32'hFFFF_FFFF;
        mirq = 1'b0;
        movf = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_irq", timer_irq, 1'b0);
        check("arst_data_o", data_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 0, CYA, 0, 0, 0, 1, 32'h0);
        step(1, 0, CYA, 0, 0, 0, 1, 32'h1);
        step(1, 0, 32'h40, 0, 0, 0, 1, 32'hDEAD_BEAA);
        step(1, 0, STA, 0, 0, 0, 1, 32'h1);
        re = 1'b0;
        we = 1'b0;
        @(negedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side responder for the pipeline CPU's memory port: it serves the CPU's loads and stores from an on-chip word RAM and a small memory-mapped I/O window. The window holds a console transmit FIFO, a free-running cycle counter and a compare interrupt. It replaces the plain memory model on the CPU's `mem_*` port in the SOPC bench and in synthesis builds. Instruction fetch is not handled here.

## Interface

Parameters:
- `RamAddrBits`, default 10: RAM depth is 2^RamAddrBits 32-bit words.
- `FifoDepth`, default 8: console FIFO entries; must be a power of 2.
- `MmioBase`, default 32'h1000_0000: base address of the MMIO window. The window size is 16 bytes.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `re`  in  1: read enable, driven from CPU `mem_re`.
- `we`  in  1: write enable, driven from CPU `mem_we`.
- `addr_i`  in  32: byte address, driven from CPU `mem_addr`.
- `data_i`  in  32: write data, driven from CPU `data_to_write_mem`.
- `byte_slct`  in  4: byte lane enables, driven from CPU `mem_byte_slct`. Bit i enables `data_i[8i+7:8i]`.
- `data_o`  out  32: read data, returned to CPU `data_from_mem`.
- `tx_data`  out  8: console byte at the FIFO head.
- `tx_valid`  out  1: FIFO is non-empty.
- `tx_ready`  in  1: the console sink accepts the head byte this cycle.
- `timer_irq`  out  1: sticky compare-match interrupt.

## Operation

- Address decode:
  - MMIO when `addr_i[31:4] == MmioBase[31:4]`.
  - RAM otherwise.
- RAM addressing:
  - Word index is `addr_i[RamAddrBits+1:2]`; higher bits are ignored, so accesses alias modulo the RAM size.
  - `addr_i[1:0]` is ignored.
- RAM behaviour:
  - Writes are per byte lane, under `byte_slct`.
  - Contents are not reset.
- Reads:
  - `data_o` is combinational: selected word when `re`=1, 0 when `re`=0.
  - Always a full word; the CPU extracts lanes itself.
- MMIO registers (offset, behaviour):
  - 0x0 TX:
    - Write with `byte_slct[0]`=1 pushes `data_i[7:0]`.
    - Write with `byte_slct[0]`=0 is ignored.
    - Reads 0.
  - 0x4 STATUS:
    - Read returns {28'b0, irq, ovf, full, empty}.
    - Writing 1 to bit 2 clears `ovf`; other bits are read-only.
  - 0x8 CYCLE:
    - Free-running 32-bit counter, wraps from FFFF_FFFF to 0.
    - A write with `byte_slct`=4'hF loads `data_i`; partial writes are ignored.
  - 0xC COMPARE:
    - Read/write, full-word writes only.
    - Any accepted write also clears `timer_irq`.
- FIFO:
  - Head is driven on `tx_data`; `tx_valid` = !empty.
  - Pop on `tx_valid && tx_ready`.
  - Push while full and no pop in the same cycle: byte dropped, `ovf` set (sticky).
  - Push while full with a pop in the same cycle: byte accepted, count unchanged.
  - Push and pop on an empty FIFO: push only (`tx_valid` was 0).
- Timer:
  - `timer_irq` sets on the edge after CYCLE == COMPARE.
  - It holds until COMPARE is written.
  - If set and clear coincide, the clear wins.
- `we` and `re` both high: `data_o` shows pre-write contents; the write lands at the edge.

## Timing

- Reset (`rst`=0, asynchronous) forces:
  - CYCLE=0, COMPARE=FFFF_FFFF.
  - FIFO pointers and count = 0, `ovf`=0, `timer_irq`=0.
  - `tx_valid`=0, `tx_data`=0.
  - `data_o`=0 regardless of `re`.
  - RAM is untouched.
- Reset asserted mid-transfer discards FIFO contents immediately; `tx_valid` falls without waiting for a clock.
- Read latency is 0 cycles: `data_o` is valid in the same cycle as `re` and `addr_i`.
- Write takes effect at the next rising edge; a read in the following cycle returns the new data.
- CYCLE:
  - Increments every cycle after reset release.
  - A load at edge N makes CYCLE = `data_i` after N and `data_i`+1 after N+1.
- FIFO:
  - A push at edge N raises `tx_valid` after N.
  - A pop at edge N advances `tx_data` after N.
- STATUS reads reflect register state before the current edge.

## Test plan

- RAM byte lanes:
  - Write 32'hDEADBEEF to 0x40 with `byte_slct`=4'hF, then write 32'h000000AA with 4'h1.
  - Read of 0x40 returns 32'hDEADBEAA; read of 0x1040 (alias with RamAddrBits=10) returns the same.
- Console FIFO:
  - With `tx_ready`=0, push bytes 0x41..0x49 (9 pushes).
  - STATUS = 0x6 (full, ovf).
  - Raise `tx_ready`: `tx_data` sequence is 0x41..0x48 on 8 consecutive cycles, then `tx_valid`=0 and STATUS = 0x5.
- Full simultaneous push/pop:
  - Fill to 8 entries, then push 0x5A in the same cycle as a pop.
  - `ovf` stays 0; 0x5A is drained last.
- Timer:
  - Write CYCLE=100 and COMPARE=105 on consecutive cycles.
  - `timer_irq` rises after CYCLE reads 105; STATUS bit 3 = 1.
  - A write to COMPARE drops `timer_irq` next cycle.
- Async reset mid-operation:
  - Assert `rst`=0 between edges with 3 bytes queued and `timer_irq`=1.
  - `tx_valid`, `timer_irq` and `data_o` drop to 0 immediately.
  - After release, CYCLE reads 0 then counts up; RAM word at 0x40 is preserved.
